// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - opcodes, FSM encoding, forward selects and scoreboard entry for the hazard controller
package pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01
  } state_t;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic [4:0] dest;
    logic       memop;
    logic       memread;
    logic [4:0] rs;
    logic [4:0] rt;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '0;

  // Unused source fields are left at r0, so they can never match a hazard or forward.
  function automatic sb_entry_t decode_id(input logic valid, input logic [5:0] op,
                                          input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd);
    sb_entry_t e;
    e = SB_BUBBLE;
    if (valid) begin
      e.valid = 1'b1;
      case (op)
        OP_RTYPE: begin e.regwrite = 1'b1; e.dest = rd; e.rs = rs; e.rt = rt; end
        OP_LW:    begin e.regwrite = 1'b1; e.dest = rt; e.rs = rs; e.memop = 1'b1; e.memread = 1'b1; end
        OP_SW:    begin e.rs = rs; e.rt = rt; e.memop = 1'b1; end
        OP_BEQ:   begin e.rs = rs; e.rt = rt; end
        default:  ;
      endcase
    end
    return e;
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - EX operand forward select; the younger MEM result wins over WB
module hazard_fwd_unit (
  input  logic [4:0] src,
  input  logic       mem_wr,
  input  logic [4:0] mem_dest,
  input  logic       wb_wr,
  input  logic [4:0] wb_dest,
  output logic [1:0] sel
);
  import pipe_pkg::*;

  always_comb begin
    sel = FWD_RF;
    if (mem_wr && (mem_dest != '0) && (mem_dest == src)) begin
      sel = FWD_EXMEM;
    end else if (wb_wr && (wb_dest != '0) && (wb_dest == src)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/forward control and data-memory wait FSM for the 5-stage core
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [5:0] id_opcode,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] id_rd,
  input  logic       ex_branch_taken,
  input  logic       dmem_ready,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       ifid_flush,
  output logic       idex_en,
  output logic       idex_flush,
  output logic       exmem_en,
  output logic       memwb_flush,
  output logic       jump_redirect,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       mem_timeout,
  output logic [1:0] state
);
  import pipe_pkg::*;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT - 1);

  state_t           st;
  logic [CNT_W-1:0] wait_cnt;
  sb_entry_t        id_sb, ex_sb, mem_sb, wb_sb;
  logic             freeze, branch, load_use, jump;
  logic [1:0]       fwd_a_raw, fwd_b_raw;
  logic             sb_unused;

  assign id_sb     = decode_id(id_valid, id_opcode, id_rs, id_rt, id_rd);
  assign freeze    = !dmem_ready && ((st == ST_MEM_WAIT) || (mem_sb.valid && mem_sb.memop));
  assign branch    = ex_branch_taken && ex_sb.valid;
  assign load_use  = id_valid && ex_sb.memread && (ex_sb.dest != '0) &&
                     ((id_sb.rs == ex_sb.dest) || (id_sb.rt == ex_sb.dest));
  assign jump      = id_valid && (id_opcode == OP_J);
  assign state     = st;
  assign sb_unused = ^wb_sb;

  hazard_fwd_unit u_fwd_a (
    .src(ex_sb.rs), .mem_wr(mem_sb.regwrite), .mem_dest(mem_sb.dest),
    .wb_wr(wb_sb.regwrite), .wb_dest(wb_sb.dest), .sel(fwd_a_raw)
  );

  hazard_fwd_unit u_fwd_b (
    .src(ex_sb.rt), .mem_wr(mem_sb.regwrite), .mem_dest(mem_sb.dest),
    .wb_wr(wb_sb.regwrite), .wb_dest(wb_sb.dest), .sel(fwd_b_raw)
  );

  always_comb begin
    pc_en         = 1'b1;
    ifid_en       = 1'b1;
    ifid_flush    = 1'b0;
    idex_en       = 1'b1;
    idex_flush    = 1'b0;
    exmem_en      = 1'b1;
    memwb_flush   = 1'b0;
    jump_redirect = 1'b0;
    fwd_a         = fwd_a_raw;
    fwd_b         = fwd_b_raw;
    if (reset) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
      fwd_a       = FWD_RF;
      fwd_b       = FWD_RF;
    end else if (freeze) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (branch) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_flush  = 1'b1;
    end else if (jump) begin
      jump_redirect = 1'b1;
      ifid_flush    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= ST_RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      ex_sb       <= SB_BUBBLE;
      mem_sb      <= SB_BUBBLE;
      wb_sb       <= SB_BUBBLE;
    end else begin
      // A frozen pipe holds EX and MEM and drains WB, so the held op never retires twice.
      if (freeze) begin
        wb_sb <= SB_BUBBLE;
      end else begin
        wb_sb  <= mem_sb;
        mem_sb <= ex_sb;
        ex_sb  <= idex_flush ? SB_BUBBLE : id_sb;
      end
      case (st)
        ST_RUN: begin
          if (freeze) begin
            st       <= ST_MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        ST_MEM_WAIT: begin
          if (dmem_ready) begin
            st <= ST_RUN;
          end else begin
            if (wait_cnt != '1) wait_cnt <= wait_cnt + CNT_W'(1);
            if (wait_cnt == TIMEOUT_CNT) mem_timeout <= 1'b1;
          end
        end
        default: st <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed vectors with an expected-output queue drained by a negedge monitor
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset, id_valid, ex_branch_taken, dmem_ready;
  logic [5:0] id_opcode;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush, jump_redirect;
  logic [1:0] fwd_a, fwd_b, state;
  logic       mem_timeout;

  int checks = 0;
  int errors = 0;
  int vec_idx = 0;
  logic [14:0] exp_q[$];

  localparam logic [5:0] RT = 6'b000000;
  localparam logic [5:0] LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011;
  localparam logic [5:0] JP = 6'b000010;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush, jump_redirect}
  localparam logic [7:0] NRM = 8'b11010100;
  localparam logic [7:0] FRZ = 8'b00000010;
  localparam logic [7:0] RST = 8'b00101010;
  localparam logic [7:0] STL = 8'b00011100;
  localparam logic [7:0] BRN = 8'b11111100;
  localparam logic [7:0] JMP = 8'b11110101;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
    .dmem_ready(dmem_ready), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_flush(memwb_flush),
    .jump_redirect(jump_redirect), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_timeout(mem_timeout), .state(state)
  );

  function automatic logic [14:0] o(input logic [7:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                                    input logic to, input logic [1:0] st);
    return {ctl, fa, fb, to, st};
  endfunction

  task automatic cyc(input bit rst, input bit v, input logic [5:0] op, input logic [4:0] rs,
                     input logic [4:0] rt, input logic [4:0] rd, input bit br, input bit rdy,
                     input logic [14:0] e);
    reset = rst; id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd;
    ex_branch_taken = br; dmem_ready = rdy;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic nop(input bit rdy, input logic [14:0] e);
    cyc(1'b0, 1'b0, RT, 5'd0, 5'd0, 5'd0, 1'b0, rdy, e);
  endtask

  logic [14:0] act, want;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      want = exp_q.pop_front();
      act  = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush,
              jump_redirect, fwd_a, fwd_b, mem_timeout, state};
      checks++;
      if (act !== want) begin
        errors++;
        $display("FAIL vec%0d outputs {ctl,fa,fb,to,st}: got %b required %b", vec_idx, act, want);
      end
      vec_idx++;
    end
  end

  initial begin
    reset = 1'b1; id_valid = 1'b0; id_opcode = RT; id_rs = '0; id_rt = '0; id_rd = '0;
    ex_branch_taken = 1'b0; dmem_ready = 1'b1;
    @(posedge clk); #1;
    cyc(1, 0, RT, 0, 0, 0, 0, 1, o(RST, 2'b00, 2'b00, 0, 2'b00));

    checks++;
    if (state !== 2'b00 || mem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset state: state=%b mem_timeout=%b required state=00 mem_timeout=0",
               state, mem_timeout);
    end

    // load-use: lw r2,(r1) then add r3,r2,r4
    cyc(0, 1, LW, 1, 2, 0, 0, 1, o(NRM, 2'b00, 2'b00, 0, 2'b00));
    cyc(0, 1, RT, 2, 4, 3, 0, 1, o(STL, 2'b00, 2'b00, 0, 2'b00));
    cyc(0, 1, RT, 2, 4, 3, 0, 1, o(NRM, 2'b00, 2'b00, 0, 2'b00));
    nop(1, o(NRM, 2'b01, 2'b00, 0, 2'b00));

    // forwarding chain, MEM-over-WB precedence, r0 never forwarded
    cyc(0, 1, RT, 1, 1, 5, 0, 1, o(NRM, 2'b00, 2'b00, 0, 2'b00));
    cyc(0, 1, RT, 5, 5, 6, 0, 1, o(NRM, 2'b00, 2'b00, 0, 2'b00));
    cyc(0, 1, RT, 6, 5, 6, 0, 1, o(NRM, 2'b10, 2'b10, 0, 2'b00));
    cyc(0, 1, RT, 6, 0, 7, 0, 1, o(NRM, 2'b10, 2'b01, 0, 2'b00));
    cyc(0, 1, RT, 1, 1, 0, 0, 1, o(NRM, 2'b10, 2'b00, 0, 2'b00));
    cyc(0, 1, RT, 0, 0, 8, 0, 1, o(NRM, 2'b00, 2'b00, 0, 2'b00));
    nop(1, o(NRM, 2'b00, 2'b00, 0, 2'b00));
    nop(1, o(NRM, 2'b00, 2'b00, 0, 2'b00));

    // SW waits three cycles on data memory
    cyc(0, 1, SW, 1, 2, 0, 0, 1, o(NRM, 2'b00, 2'b00, 0, 2'b00));
    nop(1, o(NRM, 2'b00, 2'b00, 0, 2'b00));
    nop(0, o(FRZ, 2'b00, 2'b00, 0, 2'b00));
    nop(0, o(FRZ, 2'b00, 2'b00, 0, 2'b01));
    nop(0, o(FRZ, 2'b00, 2'b00, 0, 2'b01));
    nop(1, o(NRM, 2'b00, 2'b00, 0, 2'b01));
    nop(1, o(NRM, 2'b00, 2'b00, 0, 2'b00));

    // LW waits long enough to time out; flag is sticky past release
    cyc(0, 1, LW, 1, 9, 0, 0, 1, o(NRM, 2'b00, 2'b00, 0, 2'b00));
    nop(1, o(NRM, 2'b00, 2'b00, 0, 2'b00));
    nop(0, o(FRZ, 2'b00, 2'b00, 0, 2'b00));
    for (int i = 0; i < 16; i++) nop(0, o(FRZ, 2'b00, 2'b00, 0, 2'b01));
    nop(0, o(FRZ, 2'b00, 2'b00, 1, 2'b01));
    nop(1, o(NRM, 2'b00, 2'b00, 1, 2'b01));
    nop(1, o(NRM, 2'b00, 2'b00, 1, 2'b00));

    checks++;
    if (mem_timeout !== 1'b1 || state !== 2'b00) begin
      errors++;
      $display("FAIL expired wait: mem_timeout=%b state=%b required mem_timeout=1 state=00",
               mem_timeout, state);
    end

    // taken branch outranks a simultaneous load-use
    cyc(0, 1, LW, 1, 10, 0, 0, 1, o(NRM, 2'b00, 2'b00, 1, 2'b00));
    cyc(0, 1, RT, 10, 10, 11, 1, 1, o(BRN, 2'b00, 2'b00, 1, 2'b00));
    cyc(0, 1, RT, 10, 10, 11, 0, 1, o(NRM, 2'b00, 2'b00, 1, 2'b00));

    // reset in the middle of a wait, then a jump
    cyc(0, 1, SW, 1, 2, 0, 0, 1, o(NRM, 2'b01, 2'b01, 1, 2'b00));
    nop(1, o(NRM, 2'b00, 2'b00, 1, 2'b00));
    nop(0, o(FRZ, 2'b00, 2'b00, 1, 2'b00));
    nop(0, o(FRZ, 2'b00, 2'b00, 1, 2'b01));
    cyc(1, 0, RT, 0, 0, 0, 0, 0, o(RST, 2'b00, 2'b00, 1, 2'b01));

    checks++;
    if (state !== 2'b00 || mem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset mid-wait: state=%b mem_timeout=%b required state=00 mem_timeout=0",
               state, mem_timeout);
    end

    cyc(0, 1, JP, 0, 0, 0, 0, 1, o(JMP, 2'b00, 2'b00, 0, 2'b00));
    nop(1, o(NRM, 2'b00, 2'b00, 0, 2'b00));

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
